// File: rtl/stripe_if.sv
// Job descriptor, tagged operand bus and result handshake for stripe_engine.
interface stripe_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 12
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [1:0]              cfg_op;
  logic [TAG_W-1:0]        cfg_tag_a;
  logic [TAG_W-1:0]        cfg_tag_b;
  logic [TAG_W-1:0]        cfg_stride_a;
  logic [TAG_W-1:0]        cfg_stride_b;
  logic [TAG_W-1:0]        cfg_iter_lim;
  logic                    bus_valid;
  logic [TAG_W-1:0]        bus_tag;
  logic [LANES*DATA_W-1:0] bus_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    busy;

  modport slave (
    input  cfg_valid, cfg_op, cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b,
           cfg_iter_lim, bus_valid, bus_tag, bus_data, out_ready,
    output cfg_ready, out_valid, out_data, busy
  );

  modport master (
    output cfg_valid, cfg_op, cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b,
           cfg_iter_lim, bus_valid, bus_tag, bus_data, out_ready,
    input  cfg_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/stripe_engine.sv
// Multi-lane fixed-point stripe accumulator fed by tag-matched operand beats.
// Define STRIPE_SAT_EN to saturate lane results instead of wrapping them.
//
// state | meaning
// IDLE  | waiting for a job descriptor (cfg_ready=1)
// LOAD  | snooping the bus for the current A/B tags
// EXEC  | one-cycle accumulate, advance tags and iteration count
// DONE  | result presented until the collector accepts it
module stripe_engine #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int FRAC   = 14,
  parameter int ACC_W  = 40,
  parameter int TAG_W  = 12
) (
  input logic     clk,
  input logic     rst,
  stripe_if.slave io
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                op_q, op_d;
  logic [TAG_W-1:0]          tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic [TAG_W-1:0]          stride_a_q, stride_a_d, stride_b_q, stride_b_d;
  logic [TAG_W-1:0]          iter_lim_q, iter_lim_d, iter_cnt_q, iter_cnt_d;
  logic                      have_a_q, have_a_d, have_b_q, have_b_d;
  logic signed [DATA_W-1:0]  a_q [LANES];
  logic signed [DATA_W-1:0]  a_d [LANES];
  logic signed [DATA_W-1:0]  b_q [LANES];
  logic signed [DATA_W-1:0]  b_d [LANES];
  logic signed [ACC_W-1:0]   acc_q [LANES];
  logic signed [ACC_W-1:0]   acc_d [LANES];
  logic signed [ACC_W-1:0]   acc_upd [LANES];
  logic signed [DATA_W:0]    sum_w [LANES];
  logic signed [DATA_W:0]    dif_w [LANES];
  logic signed [2*DATA_W-1:0] prod_w [LANES];
  logic [LANES*DATA_W-1:0]   res_w, out_data_q, out_data_d;
  logic                      load_out;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_w[i]  = (DATA_W+1)'(a_q[i]) + (DATA_W+1)'(b_q[i]);
      dif_w[i]  = (DATA_W+1)'(a_q[i]) - (DATA_W+1)'(b_q[i]);
      prod_w[i] = (2*DATA_W)'(a_q[i]) * (2*DATA_W)'(b_q[i]);
      case (op_q)
        2'd0:    acc_upd[i] = acc_q[i] + (ACC_W'(sum_w[i]) <<< FRAC);
        2'd1:    acc_upd[i] = acc_q[i] + (ACC_W'(dif_w[i]) <<< FRAC);
        2'd2:    acc_upd[i] = acc_q[i] + ACC_W'(prod_w[i]);
        default: acc_upd[i] = acc_q[i] - ACC_W'(prod_w[i]);
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_a_d    = tag_a_q;
    tag_b_d    = tag_b_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
    iter_lim_d = iter_lim_q;
    iter_cnt_d = iter_cnt_q;
    have_a_d   = have_a_q;
    have_b_d   = have_b_q;
    load_out   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a_d[i]   = a_q[i];
      b_d[i]   = b_q[i];
      acc_d[i] = acc_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (io.cfg_valid) begin
          op_d       = io.cfg_op;
          tag_a_d    = io.cfg_tag_a;
          tag_b_d    = io.cfg_tag_b;
          stride_a_d = io.cfg_stride_a;
          stride_b_d = io.cfg_stride_b;
          iter_lim_d = io.cfg_iter_lim;
          iter_cnt_d = '0;
          have_a_d   = 1'b0;
          have_b_d   = 1'b0;
          for (int i = 0; i < LANES; i++) acc_d[i] = '0;
          // A zero-length job goes straight to DONE with a zero result
          if (io.cfg_iter_lim == '0) begin
            state_d  = S_DONE;
            load_out = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (io.bus_valid && io.bus_tag == tag_a_q && !have_a_q) begin
          have_a_d = 1'b1;
          for (int i = 0; i < LANES; i++) a_d[i] = io.bus_data[i*DATA_W +: DATA_W];
        end
        if (io.bus_valid && io.bus_tag == tag_b_q && !have_b_q) begin
          have_b_d = 1'b1;
          for (int i = 0; i < LANES; i++) b_d[i] = io.bus_data[i*DATA_W +: DATA_W];
        end
        if (have_a_d && have_b_d) state_d = S_EXEC;
      end
      S_EXEC: begin
        for (int i = 0; i < LANES; i++) acc_d[i] = acc_upd[i];
        tag_a_d    = tag_a_q + stride_a_q;
        tag_b_d    = tag_b_q + stride_b_q;
        iter_cnt_d = iter_cnt_q + TAG_W'(1);
        have_a_d   = 1'b0;
        have_b_d   = 1'b0;
        if (iter_cnt_d == iter_lim_q) begin
          state_d  = S_DONE;
          load_out = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef STRIPE_SAT_EN
  logic [ACC_W-FRAC-DATA_W:0] hi_w [LANES];

  // Bits above the lane window must all equal the lane sign bit to be in range
  always_comb begin
    res_w = '0;
    for (int i = 0; i < LANES; i++) begin
      hi_w[i] = acc_d[i][ACC_W-1:FRAC+DATA_W-1];
      if ((&hi_w[i]) || !(|hi_w[i]))
        res_w[i*DATA_W +: DATA_W] = acc_d[i][FRAC +: DATA_W];
      else if (acc_d[i][ACC_W-1])
        res_w[i*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
      else
        res_w[i*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    res_w = '0;
    for (int i = 0; i < LANES; i++) res_w[i*DATA_W +: DATA_W] = acc_d[i][FRAC +: DATA_W];
  end
`endif

  assign out_data_d = load_out ? res_w : out_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      tag_a_q    <= '0;
      tag_b_q    <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      iter_lim_q <= '0;
      iter_cnt_q <= '0;
      have_a_q   <= 1'b0;
      have_b_q   <= 1'b0;
      out_data_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tag_a_q    <= tag_a_d;
      tag_b_q    <= tag_b_d;
      stride_a_q <= stride_a_d;
      stride_b_q <= stride_b_d;
      iter_lim_q <= iter_lim_d;
      iter_cnt_q <= iter_cnt_d;
      have_a_q   <= have_a_d;
      have_b_q   <= have_b_d;
      out_data_q <= out_data_d;
      for (int i = 0; i < LANES; i++) begin
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign io.cfg_ready = (state_q == S_IDLE);
  assign io.busy      = (state_q != S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.out_data  = out_data_q;
endmodule

// File: doc/stripe_engine.md
Name: stripe_engine

Overview:
Parametrised successor of the fixed 8-lane stripe/PE pair. It holds LANES lanes of Q(DATA_W-FRAC-1).FRAC two's-complement datapath. It snoops a tagged operand bus, captures the A and B operands whose tags match two striding tag pointers, and accumulates a selected op per lane over a configured iteration count. The result is returned through a valid/ready handshake. It sits between the operand broadcast bus and the result collector.

Parameters:
LANES, 8, number of parallel lanes
DATA_W, 16, lane operand/result width (two's complement)
FRAC, 14, fractional bits of operands and result
ACC_W, 40, per-lane accumulator width (must be >= 2*DATA_W)
TAG_W, 12, tag/stride/iteration field width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  high only in IDLE
cfg_op  in  2  0 ADD, 1 SUB, 2 MAC, 3 MSUB
cfg_tag_a  in  TAG_W  first A tag
cfg_tag_b  in  TAG_W  first B tag
cfg_stride_a  in  TAG_W  A tag increment per iteration
cfg_stride_b  in  TAG_W  B tag increment per iteration
cfg_iter_lim  in  TAG_W  number of iterations
bus_valid  in  1  operand beat valid
bus_tag  in  TAG_W  beat tag
bus_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
out_valid  out  1  result valid
out_ready  in  1  collector accepts result
out_data  out  LANES*DATA_W  per-lane result, same packing as bus_data
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, EXEC, DONE. Reset is asynchronous and active-low.
- Reset values: state IDLE, all accumulators 0, have_a/have_b 0, iter_cnt 0, out_valid 0, busy 0, cfg_ready 1, out_data 0.
- IDLE: when cfg_valid and cfg_ready are both high, latch all cfg_* fields, clear the accumulators and iter_cnt, and go to LOAD. If cfg_iter_lim == 0, go to DONE instead; all accumulators are 0.
- LOAD: a beat with bus_valid=1 and bus_tag==tag_a while have_a=0 latches the A operands for all lanes and sets have_a. The same rule applies to B with tag_b. If tag_a==tag_b, one beat fills both.
- In LOAD, beats with non-matching tags are ignored. A matching beat is also ignored if its flag is already set (first capture wins).
- When have_a and have_b are both high, go to EXEC on the next edge. The completing beat may arrive on the same edge as the earlier half.
- EXEC lasts one cycle and updates each lane: ADD acc += sext(a+b)<<FRAC; SUB acc += sext(a-b)<<FRAC; MAC acc += sext(a*b); MSUB acc -= sext(a*b).
  - The sum and difference are computed at DATA_W+1 bits before extension.
  - The accumulator wraps modulo 2^ACC_W.
- Also in EXEC: tag_a += stride_a and tag_b += stride_b (both wrap modulo 2^TAG_W), iter_cnt increments, and the flags clear. If the new iter_cnt == iter_lim, go to DONE; otherwise go to LOAD. Bus beats during EXEC are ignored.
- Latency: if the completing beat is sampled at edge N, the accumulate and the transition to DONE happen at edge N+1, and out_valid is high after edge N+1.
- DONE: out_valid=1. Each lane's out_data = (acc >>> FRAC)[DATA_W-1:0], i.e. arithmetic shift then truncate. out_data stays stable while out_ready=0.
  - When out_valid and out_ready are both high, go to IDLE.
  - cfg_ready is 0 throughout DONE, so a new job cannot be accepted on the handshake cycle.
  - Bus beats are ignored.
- out_data is registered, loaded on entry to DONE, and keeps its value in IDLE until the next DONE.
- Reset asserted mid-job: all state returns to reset values immediately, without waiting for a clock edge. The partial job is discarded.

Optional Feature:
STRIPE_SAT_EN.
- Defined: each lane result saturates. If acc >>> FRAC exceeds the DATA_W signed range, the lane outputs 0x7FFF (above range) or 0x8000 (below range), scaled to DATA_W.
- Undefined: truncation wrap as in Behaviour.

Test Plan:
1. MAC, tags A=0x010 stride 1, B=0x100 stride 1, iter_lim 3; every A beat 0x4000 (1.0) and every B beat 0x2000 (0.5) on all lanes -> out_data lanes 0x6000. out_valid rises one edge after the EXEC cycle following the last beat.
2. MAC, iter_lim 4, same operands -> without STRIPE_SAT_EN lanes 0x8000 (wrap); with it, lanes 0x7FFF.
3. ADD, A 0x010 stride 1, B 0x100 stride 2, iter_lim 2. Beats in order: 0x055 (junk), 0x010 a=0x1000, 0x100 b=0x0800, 0x011 a=0x1000, 0x102 b=0x0800 -> lanes 0x3000; the junk beat changes nothing.
4. tag_a=tag_b=0x020, MAC, iter_lim 1, single beat lane i = 0x2000 -> lanes 0x1000; per-lane distinct values give per-lane squares.
5. out_ready held 0 for 5 cycles in DONE -> out_valid held, out_data stable, cfg_ready 0, beats ignored. After accept, next edge IDLE and cfg_ready 1.
6. rst pulled low mid-LOAD between clock edges -> busy, out_valid, have flags go 0 before the next edge. After release with iter_lim 0, a new job reaches DONE with out_data 0.
